// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT constants, FP4 field widths and AGU state encoding
// Purpose: common definitions imported by the FFT address generation blocks.
// Ports: none (package).
package fft_pkg;

    // Default largest transform size handled by the AGU.
    localparam int MAX_N_DEF = 32;

    // FP4 sample format: sign 1, exponent 2, mantissa 1; complex word is re/im pair.
    localparam int FP4_SIGN_W = 1;
    localparam int FP4_EXP_W  = 2;
    localparam int FP4_MANT_W = 1;
    localparam int FP4_W      = FP4_SIGN_W + FP4_EXP_W + FP4_MANT_W;
    localparam int CPLX_W     = 2 * FP4_W;

    typedef enum logic [1:0] {
        AGU_IDLE = 2'd0,
        AGU_RUN  = 2'd1,
        AGU_DONE = 2'd2
    } agu_state_t;

endpackage

// File: rtl/fft_agu_dyn_if.sv
// rtl/fft_agu_dyn_if.sv - control/address bundle between FFT sequencer and the AGU
// Purpose: groups the start/step handshake and the generated addresses.
// Modports: master (sequencer/datapath side), slave (AGU side).
// Signals: start, log2_n, next_step -> AGU; valid, idx_a, idx_b, tw_idx, stage,
//          busy, done, cfg_err <- AGU.
// Optional (FFT_AGU_BITREV_EN): ld_addr -> AGU, ld_addr_rev <- AGU.
interface fft_agu_dyn_if #(
    parameter int MAX_N = fft_pkg::MAX_N_DEF
);
    localparam int ADDR_WIDTH = $clog2(MAX_N);
    localparam int LOG_W      = $clog2(ADDR_WIDTH + 1);

    logic                  start;
    logic [LOG_W-1:0]      log2_n;
    logic                  next_step;
    logic                  valid;
    logic [ADDR_WIDTH-1:0] idx_a;
    logic [ADDR_WIDTH-1:0] idx_b;
    logic [ADDR_WIDTH-2:0] tw_idx;
    logic [LOG_W-1:0]      stage;
    logic                  busy;
    logic                  done;
    logic                  cfg_err;
`ifdef FFT_AGU_BITREV_EN
    logic [ADDR_WIDTH-1:0] ld_addr;
    logic [ADDR_WIDTH-1:0] ld_addr_rev;
`endif

`ifdef FFT_AGU_BITREV_EN
    modport master (
        output start, log2_n, next_step, ld_addr,
        input  valid, idx_a, idx_b, tw_idx, stage, busy, done, cfg_err, ld_addr_rev
    );
    modport slave (
        input  start, log2_n, next_step, ld_addr,
        output valid, idx_a, idx_b, tw_idx, stage, busy, done, cfg_err, ld_addr_rev
    );
`else
    modport master (
        output start, log2_n, next_step,
        input  valid, idx_a, idx_b, tw_idx, stage, busy, done, cfg_err
    );
    modport slave (
        input  start, log2_n, next_step,
        output valid, idx_a, idx_b, tw_idx, stage, busy, done, cfg_err
    );
`endif

endinterface

// File: rtl/fft_bitrev_var.sv
// rtl/fft_bitrev_var.sv - variable-width bit reverser
// Purpose: reverses the low nbits bits of addr; bits at and above nbits are 0.
// Ports: addr [W-1:0] in, nbits [LOG_W-1:0] in, rev [W-1:0] out (combinational).
module fft_bitrev_var #(
    parameter int W     = 5,
    parameter int LOG_W = 3
) (
    input  logic [W-1:0]     addr,
    input  logic [LOG_W-1:0] nbits,
    output logic [W-1:0]     rev
);
    logic [W-1:0] full_rev;

    always_comb begin
        full_rev = '0;
        for (int i = 0; i < W; i++) begin
            full_rev[i] = addr[W-1-i];
        end
        // Reversing all W bits then shifting right by W-nbits leaves exactly the
        // reversed low nbits; nbits beyond W is clamped to a full-width reversal.
        if (int'(nbits) >= W) begin
            rev = full_rev;
        end else begin
            rev = full_rev >> (W - int'(nbits));
        end
    end

endmodule

// File: rtl/fft_agu_dyn.sv
// rtl/fft_agu_dyn.sv - runtime-configurable radix-2 DIT FFT address generator
// Purpose: emits one butterfly operand pair plus twiddle index per accepted step
//          for any power-of-two N in 2..MAX_N chosen per transform via log2_n.
// Ports: clk, rst (sync active-high); bus (fft_agu_dyn_if.slave): start, log2_n,
//        next_step in; valid, idx_a, idx_b, tw_idx, stage, busy, done, cfg_err out.
// Optional macro FFT_AGU_BITREV_EN: adds bus.ld_addr / bus.ld_addr_rev bit-reversal.
module fft_agu_dyn
    import fft_pkg::*;
#(
    parameter int MAX_N      = MAX_N_DEF,
    parameter int ADDR_WIDTH = $clog2(MAX_N),
    parameter int LOG_W      = $clog2(ADDR_WIDTH + 1)
) (
    input  logic         clk,
    input  logic         rst,
    fft_agu_dyn_if.slave bus
);
    localparam int AW = ADDR_WIDTH;

    agu_state_t      state, state_n;
    logic [LOG_W-1:0] n_lat, n_lat_n;
    logic [LOG_W-1:0] stage_r, stage_n;
    logic [AW-1:0]    bfly, bfly_n;
    logic [AW-1:0]    grp, grp_n;
    logic [AW-1:0]    stride, stride_n;

    logic             valid_q, valid_n;
    logic [AW-1:0]    idx_a_q, idx_a_n;
    logic [AW-1:0]    idx_b_q, idx_b_n;
    logic [AW-2:0]    tw_q, tw_n;
    logic [LOG_W-1:0] stage_q, stage_out_n;
    logic             done_q, done_n;
    logic             cfg_err_q, cfg_err_n;

    logic [AW:0]      n_full;
    logic [AW:0]      grp_last;
    logic             bfly_at_end, grp_at_end, stage_at_end, legal, run_n;
    logic [AW-1:0]    a_calc, tw_calc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= AGU_IDLE;
            n_lat     <= '0;
            stage_r   <= '0;
            bfly      <= '0;
            grp       <= '0;
            stride    <= AW'(1);
            valid_q   <= 1'b0;
            idx_a_q   <= '0;
            idx_b_q   <= '0;
            tw_q      <= '0;
            stage_q   <= '0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state     <= state_n;
            n_lat     <= n_lat_n;
            stage_r   <= stage_n;
            bfly      <= bfly_n;
            grp       <= grp_n;
            stride    <= stride_n;
            valid_q   <= valid_n;
            idx_a_q   <= idx_a_n;
            idx_b_q   <= idx_b_n;
            tw_q      <= tw_n;
            stage_q   <= stage_out_n;
            done_q    <= done_n;
            cfg_err_q <= cfg_err_n;
        end
    end

    always_comb begin
        state_n   = state;
        n_lat_n   = n_lat;
        stage_n   = stage_r;
        bfly_n    = bfly;
        grp_n     = grp;
        stride_n  = stride;
        cfg_err_n = 1'b0;

        // Groups per stage = N >> (stage+1); one extra bit keeps N itself representable.
        n_full       = (AW+1)'(1) << n_lat;
        grp_last     = (n_full >> (stage_r + LOG_W'(1))) - (AW+1)'(1);
        bfly_at_end  = (bfly == stride - AW'(1));
        grp_at_end   = ({1'b0, grp} == grp_last);
        stage_at_end = (stage_r == n_lat - LOG_W'(1));
        legal        = (bus.log2_n != '0) && (bus.log2_n <= LOG_W'(AW));

        unique case (state)
            AGU_IDLE: begin
                if (bus.start) begin
                    if (legal) begin
                        state_n  = AGU_RUN;
                        n_lat_n  = bus.log2_n;
                        stage_n  = '0;
                        bfly_n   = '0;
                        grp_n    = '0;
                        stride_n = AW'(1);
                    end else begin
                        cfg_err_n = 1'b1;
                    end
                end
            end
            AGU_RUN: begin
                // start is deliberately not looked at here, so a start coinciding
                // with the final step is dropped.
                if (bus.next_step) begin
                    if (!bfly_at_end) begin
                        bfly_n = bfly + AW'(1);
                    end else begin
                        bfly_n = '0;
                        if (!grp_at_end) begin
                            grp_n = grp + AW'(1);
                        end else begin
                            grp_n = '0;
                            if (stage_at_end) begin
                                state_n = AGU_DONE;
                            end else begin
                                stage_n  = stage_r + LOG_W'(1);
                                stride_n = stride << 1;
                            end
                        end
                    end
                end
            end
            AGU_DONE: begin
                state_n = AGU_IDLE;
            end
            default: begin
                state_n = AGU_IDLE;
            end
        endcase

        // Outputs are computed from next-state counters so they register together.
        run_n       = (state_n == AGU_RUN);
        a_calc      = (grp_n << (stage_n + LOG_W'(1))) + bfly_n;
        tw_calc     = bfly_n << (LOG_W'(AW - 1) - stage_n);
        valid_n     = run_n;
        idx_a_n     = run_n ? a_calc : '0;
        idx_b_n     = run_n ? (a_calc + stride_n) : '0;
        tw_n        = run_n ? tw_calc[AW-2:0] : '0;
        stage_out_n = run_n ? stage_n : '0;
        done_n      = (state_n == AGU_DONE);
    end

    assign bus.valid   = valid_q;
    assign bus.idx_a   = idx_a_q;
    assign bus.idx_b   = idx_b_q;
    assign bus.tw_idx  = tw_q;
    assign bus.stage   = stage_q;
    assign bus.busy    = (state != AGU_IDLE);
    assign bus.done    = done_q;
    assign bus.cfg_err = cfg_err_q;

`ifdef FFT_AGU_BITREV_EN
    logic [LOG_W-1:0] rev_bits;

    // Live size while idle so the load path can run ahead of start.
    assign rev_bits = (state == AGU_IDLE) ? bus.log2_n : n_lat;

    fft_bitrev_var #(
        .W     (AW),
        .LOG_W (LOG_W)
    ) u_bitrev (
        .addr  (bus.ld_addr),
        .nbits (rev_bits),
        .rev   (bus.ld_addr_rev)
    );
`endif

endmodule

// File: tb/tb_fft_agu_dyn.sv
// tb/tb_fft_agu_dyn.sv - self-checking bench for fft_agu_dyn against a loop-order model
module tb_fft_agu_dyn;
    localparam int MAX_N = 32;
    localparam int AW    = 5;
    localparam int LW    = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fft_agu_dyn_if #(.MAX_N(MAX_N)) bus();

    fft_agu_dyn #(.MAX_N(MAX_N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int exp_a[$], exp_b[$], exp_tw[$], exp_st[$];
    int ptr = 0;
    int done_cnt = 0;
    int valid_cycles = 0;

    task automatic check(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Every butterfly of a radix-2 DIT transform, stage by stage, in emission order.
    function automatic void build_model(int ln);
        int n, half;
        exp_a.delete(); exp_b.delete(); exp_tw.delete(); exp_st.delete();
        n = 1 << ln;
        for (int s = 0; s < ln; s++) begin
            half = 1 << s;
            for (int g = 0; g < n / (2 * half); g++) begin
                for (int k = 0; k < half; k++) begin
                    exp_a.push_back(g * 2 * half + k);
                    exp_b.push_back(g * 2 * half + k + half);
                    exp_tw.push_back(k * (MAX_N / (2 * half)));
                    exp_st.push_back(s);
                end
            end
        end
    endfunction

    always @(negedge clk) begin
        if (bus.done) done_cnt++;
        if (!rst && bus.valid) begin
            valid_cycles++;
            if (ptr < exp_a.size()) begin
                check("idx_a", int'(bus.idx_a), exp_a[ptr]);
                check("idx_b", int'(bus.idx_b), exp_b[ptr]);
                check("tw_idx", int'(bus.tw_idx), exp_tw[ptr]);
                check("stage", int'(bus.stage), exp_st[ptr]);
                if (bus.next_step) ptr++;
            end else begin
                check("extra_valid", 1, 0);
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.next_step = 1'b0;
        bus.log2_n = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_valid", int'(bus.valid), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_idx_a", int'(bus.idx_a), 0);
        check("rst_idx_b", int'(bus.idx_b), 0);
        check("rst_tw", int'(bus.tw_idx), 0);
        check("rst_stage", int'(bus.stage), 0);
        check("rst_cfg_err", int'(bus.cfg_err), 0);
    endtask

    task automatic launch(int ln, int duty);
        build_model(ln);
        ptr = 0;
        done_cnt = 0;
        valid_cycles = 0;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.log2_n = LW'(ln);
        bus.next_step = ($urandom_range(99) < duty);
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.log2_n = LW'($urandom_range(7));
        @(negedge clk);
        check("first_valid", int'(bus.valid), 1);
        check("busy_run", int'(bus.busy), 1);
    endtask

    task automatic run(int ln, int duty, bit poke);
        bit finished = 1'b0;
        launch(ln, duty);
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            if (done_cnt != 0) begin
                finished = 1'b1;
                break;
            end
            bus.next_step = ($urandom_range(99) < duty);
            if (poke) begin
                bus.start = $urandom_range(1);
                bus.log2_n = LW'($urandom_range(7));
            end
        end
        bus.start = 1'b0;
        bus.next_step = 1'b0;
        check("run_finished", int'(finished), 1);
        check("step_count", ptr, exp_a.size());
        if (duty == 100) check("valid_cycles", valid_cycles, exp_a.size());
        @(negedge clk);
        check("post_busy", int'(bus.busy), 0);
        check("post_done", int'(bus.done), 0);
        check("post_valid", int'(bus.valid), 0);
        check("done_pulses", done_cnt, 1);
    endtask

    task automatic bad_start(int ln);
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.log2_n = LW'(ln);
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        check("cfg_err_pulse", int'(bus.cfg_err), 1);
        check("cfg_valid", int'(bus.valid), 0);
        check("cfg_busy", int'(bus.busy), 0);
        @(negedge clk);
        check("cfg_err_clear", int'(bus.cfg_err), 0);
        check("cfg_busy2", int'(bus.busy), 0);
    endtask

    task automatic mid_run_reset();
        bit reached = 1'b0;
        launch(5, 100);
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (ptr >= 20) begin
                reached = 1'b1;
                break;
            end
        end
        check("reach_step20", int'(reached), 1);
        rst = 1'b1;
        bus.next_step = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", int'(bus.valid), 0);
        check("mid_rst_busy", int'(bus.busy), 0);
        check("mid_rst_idx_a", int'(bus.idx_a), 0);
        check("mid_rst_done", int'(bus.done), 0);
        repeat (3) @(negedge clk);
        check("mid_rst_no_done", done_cnt, 0);
    endtask

    initial begin
        do_reset();

        run(5, 100, 1'b0);
        check("m32_size", exp_a.size(), 80);
        check("m32_first_a", exp_a[0], 0);
        check("m32_first_b", exp_b[0], 1);
        check("m32_first_tw", exp_tw[0], 0);
        check("m32_s1_a", exp_a[16], 0);
        check("m32_s1_b", exp_b[16], 2);
        check("m32_last_a", exp_a[79], 15);
        check("m32_last_b", exp_b[79], 31);
        check("m32_last_tw", exp_tw[79], 15);
        check("m32_last_st", exp_st[79], 4);

        run(3, 100, 1'b0);
        check("m8_size", exp_a.size(), 12);
        check("m8_s2_first_a", exp_a[8], 0);
        check("m8_s2_first_b", exp_b[8], 4);
        check("m8_s2_first_tw", exp_tw[8], 0);
        check("m8_s2_last_a", exp_a[11], 3);
        check("m8_s2_last_b", exp_b[11], 7);
        check("m8_s2_last_tw", exp_tw[11], 12);

        run(1, 100, 1'b0);
        check("m2_size", exp_a.size(), 1);
        check("m2_b", exp_b[0], 1);

        bad_start(0);
        bad_start(6);
        bad_start(7);

        for (int i = 0; i < 4; i++) run(3 + (i % 3), 50, 1'b1);
        run(5, 50, 1'b1);
        run(2, 30, 1'b1);

        mid_run_reset();
        run(5, 50, 1'b0);

`ifdef FFT_AGU_BITREV_EN
        for (int i = 0; i < 8; i++) begin
            int r, a, e;
            r = 1 + (i % AW);
            a = $urandom_range(MAX_N - 1);
            e = 0;
            for (int j = 0; j < r; j++) if (((a >> j) & 1) != 0) e |= 1 << (r - 1 - j);
            bus.log2_n = LW'(r);
            bus.ld_addr = AW'(a);
            #1;
            check("bitrev", int'(bus.ld_addr_rev), e);
            @(negedge clk);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

`ifdef FFT_AGU_BITREV_EN
    initial bus.ld_addr = '0;
`endif

endmodule

// File: doc/fft_agu_dyn.md
Name: fft_agu_dyn

Overview:
Runtime-configurable radix-2 DIT address generation unit for the FP4 FFT core. Supports any power-of-two N from 2 to MAX_N, selected per transform through log2_n, which realises the dynamic-N mode. Each step emits one butterfly operand pair (idx_a, idx_b) and a twiddle index into a single MAX_N-point twiddle ROM. Steps advance on a next_step handshake from the butterfly datapath. done pulses after the final stage.

Parameters:
MAX_N, 32, largest supported transform size; power of two, must be >= 4
ADDR_WIDTH, $clog2(MAX_N), width of sample addresses
LOG_W, $clog2(ADDR_WIDTH+1), width of log2_n and stage

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
start  in  1  begin a transform; sampled only in IDLE
log2_n  in  LOG_W  log2 of transform size; legal range 1..ADDR_WIDTH; sampled with start
next_step  in  1  datapath consumed the current pair; ignored unless valid=1
valid  out  1  idx_a, idx_b, tw_idx and stage are meaningful
idx_a  out  ADDR_WIDTH  upper-wing operand address
idx_b  out  ADDR_WIDTH  lower-wing operand address, always idx_a + stride
tw_idx  out  ADDR_WIDTH-1  twiddle exponent k for W_MAX_N^k
stage  out  LOG_W  current stage, 0..log2_n-1
busy  out  1  high in RUN and DONE
done  out  1  one-cycle pulse when the transform completes
cfg_err  out  1  one-cycle pulse when start is rejected

Behaviour:
- Reset: state=IDLE. All outputs 0. Internal counters butterfly, group and stage are 0; stride is 1.
- States:
  - IDLE -> RUN on start with a legal log2_n: latch log2_n, clear counters, set stride=1.
  - IDLE stays IDLE on start with log2_n==0 or log2_n>ADDR_WIDTH: cfg_err=1 on the next cycle.
  - RUN -> DONE when next_step is accepted on the last pair of stage log2_n-1.
  - DONE -> IDLE unconditionally after one cycle. done=1 only while in DONE.
- Latency: valid rises the cycle after start is accepted. The first pair is (0,1), tw_idx=0.
- Outputs are registered and hold steady while next_step=0 (stall of any length).
- Address arithmetic, with stride=2^stage:
  - idx_a = group*2*stride + butterfly
  - idx_b = idx_a + stride
  - tw_idx = butterfly << (ADDR_WIDTH-1-stage)
  - Computed by shifts and adds only, no multipliers.
- Loop order (butterfly innermost), applied on each accepted next_step:
  - butterfly++.
  - At butterfly==stride-1: butterfly=0, group++.
  - At group==(N>>(stage+1))-1: group=0, stage++, stride<<=1.
- Total accepted steps = (N/2)*log2_n. N=32 gives 80 steps; N=8 gives 12 steps.
- valid drops in DONE; next_step is ignored there.
- start while busy is ignored and does not change the latched log2_n.
- start and the final next_step in the same cycle: the final step wins; the start is ignored.
- rst mid-RUN: the next edge returns all state to reset values; no done pulse.
- log2_n input changes while busy have no effect.

Optional Feature:
Macro FFT_AGU_BITREV_EN.
- Defined: adds input ld_addr [ADDR_WIDTH-1:0] and output ld_addr_rev [ADDR_WIDTH-1:0].
  - ld_addr_rev is the combinational bit-reversal of the low log2_n bits of ld_addr.
  - log2_n here is the live input in IDLE and the latched value while busy.
  - Upper bits of ld_addr_rev are 0.
  - Used by the external load path for the bit-reversed write order.
- Undefined: neither port exists. The load path supplies bit-reversed addresses itself.

Decomposition:
- Shared package fft_pkg:
  - MAX_N default
  - FP4 field widths (sign 1, exp 2, mant 1; 8-bit complex word)
  - AGU state encoding: IDLE, RUN, DONE
- One natural sub-module: fft_bitrev_var, a variable-width bit reverser. Instantiated only under FFT_AGU_BITREV_EN.

Test Plan:
- N=32, log2_n=5, next_step tied to 1 -> exactly 80 valid cycles, then a one-cycle done pulse.
  - First pair (0,1) tw 0.
  - Stage 1 first pair (0,2).
  - Last pair stage 4 (15,31) tw 15.
- N=8, log2_n=3 -> 12 steps. Stage 2 pairs are (0,4) tw 0 through (3,7) tw 12. done pulses, then IDLE.
- N=2, log2_n=1 -> single pair (0,1) tw 0, then done.
- start with log2_n=0, then log2_n=6 (MAX_N=32) -> cfg_err pulses each time; valid stays 0; busy stays 0.
- next_step random with about 50% duty -> outputs stable while low. Every pair from an ideal model appears exactly once, in order.
- rst asserted at step 20 of N=32 -> next cycle valid=0, busy=0, idx_a=0, no done. A new start runs cleanly from (0,1).
